// File: rtl/cnt_seq_ctrl.sv
// rtl/cnt_seq_ctrl.sv - job sequencer driving a 4-bit presettable counter (optional pause: CNT_SEQ_PAUSE_EN)
module cnt_seq_ctrl #(
    parameter int   RPT_W    = 8,
    parameter logic IDLE_CET = 1'b0
) (
    input  logic             CP,
    input  logic             SR,
    input  logic             start,
    input  logic [3:0]       period,
    input  logic [RPT_W-1:0] n_rpt,
    input  logic             stop,
    input  logic             cnt_tc,
`ifdef CNT_SEQ_PAUSE_EN
    input  logic             pause,
`endif
    output logic [3:0]       P,
    output logic             PE,
    output logic             CEP,
    output logic             CET,
    output logic             busy,
    output logic             done,
    output logic             abort,
    output logic [RPT_W-1:0] rpt_left
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_DONE  = 3'd3,
        S_ABORT = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [RPT_W-1:0] r_rpt_left;
    logic [RPT_W-1:0] w_rpt_nxt;
    logic [3:0]       r_p;
    logic [3:0]       w_p_nxt;
    logic             r_pe;
    logic             r_cep;
    logic             r_cet;
    logic             r_busy;
    logic             r_done;
    logic             r_abort;
    logic             w_pe_nxt;
    logic             w_cep_nxt;
    logic             w_cet_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_abort_nxt;
    logic             w_pause;

`ifdef CNT_SEQ_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_rpt_nxt   = r_rpt_left;
        w_p_nxt     = r_p;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_p_nxt     = period;
                    w_rpt_nxt   = (n_rpt == '0) ? RPT_W'(1) : n_rpt;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_state_nxt = stop ? S_ABORT : S_RUN;
            end
            S_RUN: begin
                // stop wins over a coincident TC
                if (stop) begin
                    w_state_nxt = S_ABORT;
                end else if (cnt_tc) begin
                    w_rpt_nxt   = r_rpt_left - RPT_W'(1);
                    w_state_nxt = (r_rpt_left == RPT_W'(1)) ? S_DONE : S_LOAD;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_ABORT: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_state_nxt == S_ABORT) begin
            w_rpt_nxt = '0;
        end

        // outputs are decoded from the next state so they register with it
        w_pe_nxt    = (w_state_nxt != S_LOAD);
        w_cep_nxt   = (w_state_nxt == S_RUN) && !w_pause;
        w_cet_nxt   = (w_state_nxt == S_IDLE) ? IDLE_CET : (w_state_nxt == S_RUN);
        w_busy_nxt  = (w_state_nxt != S_IDLE);
        w_done_nxt  = (w_state_nxt == S_DONE);
        w_abort_nxt = (w_state_nxt == S_ABORT);
    end

    always_ff @(posedge CP or negedge SR) begin
        if (!SR) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CP or negedge SR) begin
        if (!SR) begin
            r_rpt_left <= '0;
            r_p        <= 4'h0;
            r_pe       <= 1'b1;
            r_cep      <= 1'b0;
            r_cet      <= IDLE_CET;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_abort    <= 1'b0;
        end else begin
            r_rpt_left <= w_rpt_nxt;
            r_p        <= w_p_nxt;
            r_pe       <= w_pe_nxt;
            r_cep      <= w_cep_nxt;
            r_cet      <= w_cet_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_abort    <= w_abort_nxt;
        end
    end

    assign P        = r_p;
    assign PE       = r_pe;
    assign CEP      = r_cep;
    assign CET      = r_cet;
    assign busy     = r_busy;
    assign done     = r_done;
    assign abort    = r_abort;
    assign rpt_left = r_rpt_left;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// tb/tb_cnt_seq_ctrl.sv - scoreboard bench for cnt_seq_ctrl with a behavioural 4-bit counter
module tb_cnt_seq_ctrl;

    logic       CP;
    logic       SR;
    logic       start;
    logic [3:0] period;
    logic [7:0] n_rpt;
    logic       stop;
    logic       cnt_tc;
    logic [3:0] P;
    logic       PE;
    logic       CEP;
    logic       CET;
    logic       busy;
    logic       done;
    logic       abort;
    logic [7:0] rpt_left;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        bit         is_abort;
        int         rpt;
        int         loads;
        int         busy_cyc;
        logic [31:0] trace;
        logic [3:0] p;
    } exp_t;

    exp_t exp_q[$];

    cnt_seq_ctrl #(.RPT_W(8), .IDLE_CET(1'b0)) dut (
        .CP       (CP),
        .SR       (SR),
        .start    (start),
        .period   (period),
        .n_rpt    (n_rpt),
        .stop     (stop),
        .cnt_tc   (cnt_tc),
`ifdef CNT_SEQ_PAUSE_EN
        .pause    (1'b0),
`endif
        .P        (P),
        .PE       (PE),
        .CEP      (CEP),
        .CET      (CET),
        .busy     (busy),
        .done     (done),
        .abort    (abort),
        .rpt_left (rpt_left)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    // counter model: load on PE low, count with CEP&CET, TC at 15 gated by CET
    logic [3:0] r_q;
    always_ff @(posedge CP or negedge SR) begin
        if (!SR)                r_q <= 4'h0;
        else if (!PE)           r_q <= P;
        else if (CEP && CET)    r_q <= r_q + 4'h1;
    end
    assign cnt_tc = CET && (r_q == 4'hF);

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // monitor: accumulates per-job observations and scores them on done/abort
    int          mon_busy;
    int          mon_loads;
    logic [31:0] mon_trace;
    initial begin
        exp_t e;
        mon_busy  = 0;
        mon_loads = 0;
        mon_trace = 32'h0;
        forever begin
            @(negedge CP);
            if (!SR) begin
                mon_busy  = 0;
                mon_loads = 0;
                mon_trace = 32'h0;
            end else begin
                if (busy) mon_busy++;
                if (!PE) begin
                    mon_loads++;
                    mon_trace = {mon_trace[27:0], rpt_left[3:0]};
                end
                if (done || abort) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL unexpected_response done=%0d abort=%0d required=none at %0t",
                                 done, abort, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("resp_is_abort", int'(abort), int'(e.is_abort));
                        chk("resp_is_done", int'(done), int'(!e.is_abort));
                        chk("resp_rpt_left", int'(rpt_left), e.rpt);
                        chk("resp_loads", mon_loads, e.loads);
                        chk("resp_busy_cycles", mon_busy, e.busy_cyc);
                        chk("resp_rpt_trace", int'(mon_trace), int'(e.trace));
                        chk("resp_p", int'(P), int'(e.p));
                    end
                    mon_busy  = 0;
                    mon_loads = 0;
                    mon_trace = 32'h0;
                end
            end
        end
    end

    task automatic push_exp(input bit ab, input int rpt, input int loads, input int bc,
                            input logic [31:0] tr, input logic [3:0] p);
        exp_t e;
        e.is_abort = ab;
        e.rpt      = rpt;
        e.loads    = loads;
        e.busy_cyc = bc;
        e.trace    = tr;
        e.p        = p;
        exp_q.push_back(e);
    endtask

    // issues a start pulse, scrambles the job inputs afterwards, checks the LOAD cycle
    task automatic start_job(input logic [3:0] p, input logic [7:0] n);
        @(negedge CP);
        period = p;
        n_rpt  = n;
        start  = 1'b1;
        @(negedge CP);
        start  = 1'b0;
        period = 4'(~p);
        n_rpt  = 8'(n + 8'd7);
        chk("load_busy", int'(busy), 1);
        chk("load_pe", int'(PE), 0);
        chk("load_cep", int'(CEP), 0);
        chk("load_p", int'(P), int'(p));
    endtask

    task automatic wait_idle(input int max_cyc);
        int c;
        c = 0;
        while (busy && c < max_cyc) begin
            @(negedge CP);
            c++;
        end
        if (busy) begin
            n_vec++;
            n_fail++;
            $display("FAIL wait_idle_timeout busy=%0d required=0 after %0d cycles", busy, c);
        end
        chk("idle_busy", int'(busy), 0);
        chk("idle_done", int'(done), 0);
    endtask

    initial begin
        int k;
        int c;
        bit sent;

        SR     = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
        period = 4'h0;
        n_rpt  = 8'h0;

        // reset with random inputs
        repeat (4) begin
            @(negedge CP);
            start  = 1'($urandom);
            stop   = 1'($urandom);
            period = 4'($urandom);
            n_rpt  = 8'($urandom);
        end
        #1;
        chk("rst_pe", int'(PE), 1);
        chk("rst_cep", int'(CEP), 0);
        chk("rst_cet", int'(CET), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done_abort", int'(done | abort), 0);
        chk("rst_rpt_left", int'(rpt_left), 0);
        chk("rst_p", int'(P), 0);
        @(negedge CP);
        start = 1'b0;
        stop  = 1'b0;
        SR    = 1'b1;
        repeat (3) @(negedge CP);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_pe", int'(PE), 1);
        chk("post_rst_rpt", int'(rpt_left), 0);

        // single job: 4 RUN cycles (C..F)
        push_exp(1'b0, 0, 1, 6, 32'h1, 4'hC);
        start_job(4'hC, 8'd1);
        @(negedge CP);
        chk("run_cep", int'(CEP), 1);
        chk("run_cet", int'(CET), 1);
        chk("run_pe", int'(PE), 1);
        wait_idle(100);

        // repeat: three 17-cycle segments
        push_exp(1'b0, 0, 3, 52, 32'h321, 4'h0);
        start_job(4'h0, 8'd3);
        wait_idle(200);

        // n_rpt=0 acts as 1
        push_exp(1'b0, 0, 1, 10, 32'h1, 4'h8);
        start_job(4'h8, 8'd0);
        wait_idle(100);

        // abort on the 3rd TC; a start pulse mid-job must be ignored
        push_exp(1'b1, 0, 3, 10, 32'h543, 4'hE);
        start_job(4'hE, 8'd5);
        k    = 0;
        c    = 0;
        sent = 1'b0;
        while (k < 3 && c < 100) begin
            if (cnt_tc) k++;
            if (k == 1 && !sent) begin
                start  = 1'b1;
                period = 4'h3;
                sent   = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (k == 3) stop = 1'b1;
            else begin
                @(negedge CP);
                c++;
            end
        end
        start = 1'b0;
        chk("abort_tc_count", k, 3);
        @(negedge CP);
        stop = 1'b0;
        chk("abort_pulse", int'(abort), 1);
        chk("abort_no_done", int'(done), 0);
        chk("abort_cep", int'(CEP), 0);
        chk("abort_cet", int'(CET), 0);
        chk("abort_rpt", int'(rpt_left), 0);
        @(negedge CP);
        chk("abort_one_cycle", int'(abort), 0);
        chk("abort_busy_low", int'(busy), 0);
        stop = 1'b1;
        @(negedge CP);
        stop = 1'b0;
        @(negedge CP);
        chk("idle_stop_ignored", int'(busy | abort), 0);

        // mid-job reset while rpt_left==2 in RUN
        start_job(4'hE, 8'd3);
        c = 0;
        while (!(rpt_left == 8'd2 && CEP) && c < 100) begin
            @(negedge CP);
            c++;
        end
        chk("midrst_reached", int'(rpt_left == 8'd2 && CEP), 1);
        #2;
        SR = 1'b0;
        #1;
        chk("midrst_pe", int'(PE), 1);
        chk("midrst_cep_cet", int'(CEP | CET), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done_abort", int'(done | abort), 0);
        chk("midrst_rpt", int'(rpt_left), 0);
        @(negedge CP);
        SR = 1'b1;
        push_exp(1'b0, 0, 1, 5, 32'h1, 4'hD);
        start_job(4'hD, 8'd1);
        wait_idle(100);

        repeat (3) @(negedge CP);
        chk("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout reached at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cnt_seq_ctrl.md
Name: cnt_seq_ctrl

Overview:
- Upstream control stage for the 4-bit synchronous presettable counter (P/PE/CEP/CET/TC interface).
- Accepts a job via a start/busy handshake: a preset value and a number of counter wraps.
- Drives the counter's parallel-load and enable pins, counts returned TC pulses, and signals done or abort.
- Turns the free counter into a programmable, repeatable interval timer.

Parameters:
- RPT_W, 8, width of the wrap-count request and the remaining-wrap counter.
- IDLE_CET, 0, level driven on CET while not in RUN (0 keeps the counter frozen).

Ports:
- CP  input  1  clock; all state updates on the rising edge.
- SR  input  1  reset, asynchronous, active-low.
- start  input  1  job request; sampled only in IDLE.
- period  input  4  preset value loaded into the counter (P) for every segment.
- n_rpt  input  RPT_W  number of TC pulses to wait for; 0 is treated as 1.
- stop  input  1  abort request; honoured in LOAD and RUN.
- cnt_tc  input  1  TC from the counter, one CP period high per wrap.
- P  output  4  preset value to the counter.
- PE  output  1  counter parallel-load enable, active-low.
- CEP  output  1  counter count-enable (parallel).
- CET  output  1  counter count-enable (trickle).
- busy  output  1  high from the cycle after start is accepted until return to IDLE.
- done  output  1  one-cycle pulse on normal completion.
- abort  output  1  one-cycle pulse when stop terminates a job.
- rpt_left  output  RPT_W  remaining TC pulses in the current job.

Behaviour:
- Reset (SR=0, asynchronous): state=IDLE, P=0, PE=1, CEP=0, CET=IDLE_CET, busy=0, done=0, abort=0, rpt_left=0, latched period=0.
- All outputs are registered. No combinational path from any input to any output.
- IDLE:
  - PE=1, CEP=0, CET=IDLE_CET.
  - start=1 latches period into P and loads rpt_left = (n_rpt==0 ? 1 : n_rpt).
  - Next state is LOAD; busy rises on the same edge.
- LOAD (exactly 1 cycle): PE=0, CEP=0, CET=0. Next state is RUN.
- RUN:
  - PE=1, CEP=1, CET=1.
  - On cnt_tc=1, rpt_left decrements.
  - If the decremented value is 0: next state is DONE.
  - Otherwise: next state is LOAD, reloading period for the next segment.
- DONE (1 cycle): done=1, CEP=0, CET=0, PE=1. Next state is IDLE, busy falls on that edge.
- stop=1 in LOAD or RUN: next state is ABORT, regardless of cnt_tc in the same cycle (stop wins).
- ABORT (1 cycle): abort=1, CEP=0, CET=0, PE=1, rpt_left cleared to 0. Next state is IDLE.
- start in any state other than IDLE is ignored and not queued.
- stop in IDLE or DONE is ignored.
- cnt_tc outside RUN is ignored; rpt_left does not change.
- period and n_rpt are sampled only at acceptance. Later changes do not affect a running job.
- Segment length, for the counter's behaviour (clears to 0 after TC):
  - Segment length in CP cycles = 1 (LOAD) + (16 − period) + TC turnaround.
  - The bench measures it rather than assuming it.
- Asserting SR low mid-job returns to IDLE immediately. No done or abort pulse is produced.

Optional Feature:
- Macro CNT_SEQ_PAUSE_EN.
- When defined: adds input `pause` (1 bit).
  - In RUN with pause=1: CEP=0 and CET=1, so the counter holds.
  - cnt_tc is still honoured, and rpt_left and state are held otherwise.
  - pause has no effect in other states.
  - stop overrides pause.
- When undefined: no pause port; RUN always drives CEP=1.

Test Plan:
- Reset: SR=0 with random inputs → PE=1, CEP=0, CET=0, busy=0, done=0, abort=0, rpt_left=0; held after SR=1 with start=0.
- Single job: period=4'hC, n_rpt=1, start pulse → next cycle busy=1 and PE=0 for one cycle with P=4'hC. Then CEP=CET=1 until cnt_tc. Then done=1 for one cycle, busy=0 the cycle after.
- Repeat: period=4'h0, n_rpt=3 → three LOAD cycles (PE=0) observed. rpt_left steps 3→2→1→0. Exactly one done pulse.
- n_rpt=0 → behaves as n_rpt=1; exactly one LOAD and one done pulse.
- Abort: n_rpt=5, stop asserted after 2nd cnt_tc, coincident with a 3rd cnt_tc → abort=1 for one cycle, no done, rpt_left=0, CEP=CET=0, start ignored while busy.
- Mid-job reset: SR pulsed low during RUN with rpt_left=2 → all outputs return to reset values asynchronously, and the next start begins a fresh job.
